// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core request at a time, performs byte/half/word
// loads and stores against a word-wide memory with a combinational read port,
// and returns a single response.
//
// Sub-word stores do a read-modify-write, so only the addressed lanes change.
// Lanes are little-endian: byte lane 0 is bits [7:0].
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   req_*              core request (valid/ready handshake)
//   rsp_*              core response (valid/ready handshake)
//   mem_address        word address to memory, bits [1:0] always 0
//   mem_data_in        write word to memory
//   mem_data_out       combinational read word from memory
//   mem_we             memory write enable
//
// Build option: define LSU_MISALIGN_ERR_EN to report misaligned half/word
// accesses as errors. Otherwise they are force-aligned, and only size 2'b11
// is reported as an error.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic        mem_we
);

  typedef enum logic [2:0] {StIdle, StLoad, StRmwRead, StWrite, StResp} state_e;

  state_e      state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [1:0]  off_q, off_d;        // effective byte lane after force-alignment
  logic [15:0] wdata_q, wdata_d;    // only sub-word stores need the latched data
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_error_q, rsp_error_d;
  logic [29:0] mem_word_q, mem_word_d;
  logic [31:0] mem_data_in_q, mem_data_in_d;
  logic        mem_we_q, mem_we_d;

  logic        req_err;
  logic [1:0]  req_off;
  logic [31:0] shifted;
  logic [31:0] load_val;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;
  logic [31:0] merged;

  // Request decode: error detection and effective lane offset.
  always_comb begin
    req_err = (req_size == 2'b11);
`ifdef LSU_MISALIGN_ERR_EN
    if ((req_size == 2'b01 && req_addr[0]) || (req_size == 2'b10 && req_addr[1:0] != 2'b00)) begin
      req_err = 1'b1;
    end
`endif
    unique case (req_size)
      2'b00:   req_off = req_addr[1:0];
      2'b01:   req_off = {req_addr[1], 1'b0};
      default: req_off = 2'b00;
    endcase
  end

  // Load lane extraction and store lane merge, both relative to off_q.
  always_comb begin
    shifted = mem_data_out >> {off_q, 3'b000};
    unique case (size_q)
      2'b00:   load_val = {{24{~unsigned_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = {{16{~unsigned_q & shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
    if (size_q == 2'b00) begin
      lane_mask = 32'h0000_00ff << {off_q, 3'b000};
      lane_data = {4{wdata_q[7:0]}};
    end else begin
      lane_mask = 32'h0000_ffff << {off_q, 3'b000};
      lane_data = {2{wdata_q}};
    end
    merged = (mem_data_out & ~lane_mask) | (lane_data & lane_mask);
  end

  always_comb begin
    state_d       = state_q;
    size_d        = size_q;
    unsigned_d    = unsigned_q;
    off_d         = off_q;
    wdata_d       = wdata_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_error_d   = rsp_error_q;
    mem_word_d    = mem_word_q;
    mem_data_in_d = mem_data_in_q;
    mem_we_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          size_d      = req_size;
          unsigned_d  = req_unsigned;
          off_d       = req_off;
          wdata_d     = req_wdata[15:0];
          rsp_rdata_d = 32'h0;
          rsp_error_d = 1'b0;
          if (req_err) begin
            rsp_error_d = 1'b1;
            state_d     = StResp;
          end else begin
            mem_word_d = req_addr[31:2];
            if (!req_we) begin
              state_d = StLoad;
            end else if (req_size == 2'b10) begin
              mem_data_in_d = req_wdata;
              mem_we_d      = 1'b1;
              state_d       = StWrite;
            end else begin
              state_d = StRmwRead;
            end
          end
        end
      end
      StLoad: begin
        rsp_rdata_d = load_val;
        state_d     = StResp;
      end
      StRmwRead: begin
        mem_data_in_d = merged;
        mem_we_d      = 1'b1;
        state_d       = StWrite;
      end
      StWrite: begin
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      size_q        <= 2'b00;
      unsigned_q    <= 1'b0;
      off_q         <= 2'b00;
      wdata_q       <= 16'h0;
      rsp_rdata_q   <= 32'h0;
      rsp_error_q   <= 1'b0;
      mem_word_q    <= 30'h0;
      mem_data_in_q <= 32'h0;
      mem_we_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      size_q        <= size_d;
      unsigned_q    <= unsigned_d;
      off_q         <= off_d;
      wdata_q       <= wdata_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_error_q   <= rsp_error_d;
      mem_word_q    <= mem_word_d;
      mem_data_in_q <= mem_data_in_d;
      mem_we_q      <= mem_we_d;
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign rsp_valid   = (state_q == StResp);
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_error   = rsp_error_q;
  assign mem_address = {mem_word_q, 2'b00};
  assign mem_data_in = mem_data_in_q;
  assign mem_we      = mem_we_q;

endmodule
